wdt_rst_req: RTL and testbench
==============================

Name: wdt_rst_req

Overview:
- Watchdog timer for rRISC that is the requesting side of the reset bridge: it drives the active-low reset request which the bridge turns into the system reset.
- Software enables it and must service it with a two-byte key sequence.
- On expiry it drives an active-low reset request pulse of fixed length.
- It raises a warning level before expiry so firmware can log state.

Parameters:
- PRESC_DIV, 256, clk cycles per watchdog tick; power of two, ≥2.
- WARN_TICKS, 2, remaining-tick count at which warn_o asserts; 0 disables warning.
- PULSE_LEN, 16, cycles nrst_req_o is held low on expiry; ≥1.
- KEY0, 8'h5A, first service key byte.
- KEY1, 8'hA5, second service key byte.

Ports:
- clk  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  enable request; sampled each cycle; lock-on-enable
- timeout_i  in  8  timeout in ticks; sampled on enable and on each valid kick; 0 is treated as 1
- wr_i  in  1  one-cycle service write strobe
- wdata_i  in  8  service write data
- nrst_req_o  out  1  active-low reset request to the reset bridge; registered
- warn_o  out  1  pre-expiry warning level; registered
- active_o  out  1  watchdog running (RUN or WARN)
- fired_o  out  1  sticky flag: watchdog has expired since rst_i

Behaviour:
- One clock domain; reset is synchronous and active-high on rst_i.
- Reset values:
  - nrst_req_o=1, warn_o=0, active_o=0, fired_o=0.
  - State IDLE; tick counter=0; prescaler=0; key_armed=0.
- States:
  - IDLE → RUN: en_i=1 at an edge. Load cnt=max(timeout_i,1) and presc=0.
  - RUN → WARN: cnt reaches WARN_TICKS and WARN_TICKS>0.
  - RUN/WARN → FIRE: cnt reaches 0.
  - FIRE → IDLE: after PULSE_LEN cycles.
- Lock: in RUN/WARN, en_i=0 is ignored. Only FIRE completion or rst_i return the block to IDLE.
- Ticking: presc increments every cycle in RUN/WARN. When presc wraps from PRESC_DIV-1, cnt decrements.
- Latency: with enable sampled at edge E0 and T=timeout_i, FIRE is entered at edge E0+T*PRESC_DIV. nrst_req_o is low from that edge for exactly PULSE_LEN cycles.
- warn_o: high in WARN only, asserted at the same edge cnt becomes WARN_TICKS. If timeout_i≤WARN_TICKS, WARN is entered directly from IDLE.
- Service key:
  - wr_i with wdata_i=KEY0 sets key_armed.
  - Next wr_i with KEY1 while armed is a valid kick: reload cnt=max(timeout_i,1), presc=0, clear key_armed, WARN→RUN, clear warn_o the next cycle.
  - Next wr_i with any other byte while armed, in RUN/WARN: immediate FIRE on the following edge (key violation). In IDLE: only clears key_armed.
  - KEY1 without arm is ignored. KEY0 while armed keeps it armed.
- Simultaneous kick and expiry at the same edge: kick wins; no FIRE.
- In FIRE:
  - wr_i and en_i are ignored; key_armed is cleared.
  - fired_o is set on FIRE entry and held until rst_i.
  - active_o=0, warn_o=0.
- rst_i mid-FIRE: pulse terminates immediately; nrst_req_o=1 the cycle after.
- Re-enable after FIRE→IDLE requires en_i high at an edge in IDLE. If en_i is still high, RUN restarts on the first IDLE cycle.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE, RUN, WARN, FIRE (2-bit)
  - default KEY0/KEY1 constants
- One natural sub-module, wdt_prescaler: free-running divide-by-PRESC_DIV counter with synchronous clear and one-cycle tick_o pulse.
- The FSM, key logic and pulse stretcher stay in wdt_rst_req.

Test Plan (PRESC_DIV=4, WARN_TICKS=1, PULSE_LEN=3 unless noted):
- Reset → nrst_req_o=1, warn_o=0, active_o=0, fired_o=0; en_i=0 for 50 cycles leaves all unchanged.
- Expiry: en_i=1 at E0, timeout_i=3, no writes → warn_o rises at E0+8, nrst_req_o low E0+12..E0+14, high at E0+15, fired_o=1 from E0+12.
- Service: writes 5A then A5 every 10 cycles over 200 cycles → nrst_req_o stays 1 and warn_o never asserts; deassert en_i mid-run → active_o stays 1.
- Key violation: write 5A then 33 while running → nrst_req_o low on the second edge after the 33 write; the same sequence in IDLE → no pulse, and a later lone A5 has no effect.
- Race: kick completing on the exact expiry edge E0+12 → no FIRE, cnt reloaded, warn_o cleared.
- Boundary: timeout_i=0 → fires at E0+4; rst_i asserted during FIRE's second cycle → nrst_req_o=1 next cycle, fired_o=0, state IDLE.

Source files
------------

// File: rtl/wdt_rst_req_pkg.sv
// Shared definitions for the rRISC watchdog reset requester: state encoding,
// default service keys and the timeout-to-ticks helper.
package wdt_rst_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_FIRE = 2'd3
    } wdt_state_e;

    localparam logic [7:0] KEY0_DEFAULT = 8'h5A;
    localparam logic [7:0] KEY1_DEFAULT = 8'hA5;

    // A programmed timeout of zero still gives the firmware one full tick.
    function automatic logic [7:0] load_ticks(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Divide-by-DIV tick generator for the watchdog; holds at zero while stopped
// and restarts from zero on a synchronous clear.
module wdt_prescaler #(
    parameter int DIV = 256
) (
    input  logic clk,
    input  logic rst_i,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // DIV is a power of two, so the natural binary wrap is the divide point.
    always_comb begin
        count_d = count_q + 1'b1;
        if (clr_i || !run_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = run_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/wdt_rst_req.sv
// Watchdog timer that drives the active-low reset request into the reset
// bridge: key-serviced countdown, pre-expiry warning and fixed-length pulse.
module wdt_rst_req
    import wdt_rst_req_pkg::*;
#(
    parameter int         PRESC_DIV  = 256,
    parameter int         WARN_TICKS = 2,
    parameter int         PULSE_LEN  = 16,
    parameter logic [7:0] KEY0       = KEY0_DEFAULT,
    parameter logic [7:0] KEY1       = KEY1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] timeout_i,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    output logic       nrst_req_o,
    output logic       warn_o,
    output logic       active_o,
    output logic       fired_o
);
    localparam int            PW         = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam bit            WARN_EN    = (WARN_TICKS > 0);
    localparam logic [7:0]    WARN_CNT   = 8'(WARN_TICKS);

    wdt_state_e    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic          armed_q, armed_d;
    logic          viol_q, viol_d;
    logic          nrst_q, warn_q, fired_q;

    logic          running;
    logic          tick;
    logic          wr_key0, wr_key1, wr_bad;
    logic          kick;
    logic [7:0]    load_cnt;
    logic [7:0]    cnt_dec;
    wdt_state_e    load_state;

    assign running  = (state_q == ST_RUN) || (state_q == ST_WARN);
    assign wr_key0  = wr_i && (wdata_i == KEY0);
    assign wr_key1  = wr_i && armed_q && (wdata_i == KEY1);
    assign wr_bad   = wr_i && armed_q && (wdata_i != KEY0) && (wdata_i != KEY1);
    assign kick     = running && !viol_q && wr_key1;
    assign load_cnt = load_ticks(timeout_i);
    assign cnt_dec  = cnt_q - 8'd1;
    assign load_state = (WARN_EN && (load_cnt <= WARN_CNT)) ? ST_WARN : ST_RUN;

    wdt_prescaler #(
        .DIV (PRESC_DIV)
    ) u_presc (
        .clk    (clk),
        .rst_i  (rst_i),
        .run_i  (running),
        .clr_i  (kick),
        .tick_o (tick)
    );

    // A pending key violation outranks everything; a valid kick outranks expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        armed_d = armed_q;
        viol_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_key0) begin
                    armed_d = 1'b1;
                end else if (wr_key1 || wr_bad) begin
                    armed_d = 1'b0;
                end
                if (en_i) begin
                    state_d = load_state;
                    cnt_d   = load_cnt;
                end
            end
            ST_RUN, ST_WARN: begin
                if (viol_q) begin
                    state_d = ST_FIRE;
                    pulse_d = PULSE_LAST;
                    armed_d = 1'b0;
                end else if (kick) begin
                    state_d = load_state;
                    cnt_d   = load_cnt;
                    armed_d = 1'b0;
                end else begin
                    if (wr_key0) begin
                        armed_d = 1'b1;
                    end else if (wr_bad) begin
                        armed_d = 1'b0;
                        viol_d  = 1'b1;
                    end
                    if (tick) begin
                        cnt_d = cnt_dec;
                        if (cnt_dec == 8'd0) begin
                            state_d = ST_FIRE;
                            pulse_d = PULSE_LAST;
                            armed_d = 1'b0;
                            viol_d  = 1'b0;
                        end else if (WARN_EN && (cnt_dec <= WARN_CNT)) begin
                            state_d = ST_WARN;
                        end
                    end
                end
            end
            default: begin
                armed_d = 1'b0;
                if (pulse_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    pulse_d = pulse_q - 1'b1;
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the transition edge.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            pulse_q <= '0;
            armed_q <= 1'b0;
            viol_q  <= 1'b0;
            nrst_q  <= 1'b1;
            warn_q  <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            armed_q <= armed_d;
            viol_q  <= viol_d;
            nrst_q  <= (state_d != ST_FIRE);
            warn_q  <= (state_d == ST_WARN);
            fired_q <= fired_q || (state_d == ST_FIRE);
        end
    end

    assign nrst_req_o = nrst_q;
    assign warn_o     = warn_q;
    assign active_o   = running;
    assign fired_o    = fired_q;

endmodule

// File: tb/tb_wdt_rst_req.sv
// Scoreboard bench for wdt_rst_req: a deadline-based reference model predicts
// the outputs after every edge and a monitor compares them on the falling edge.
module tb_wdt_rst_req;
    localparam int         PRESC  = 4;
    localparam int         WARN   = 1;
    localparam int         PULSE  = 3;
    localparam logic [7:0] K0     = 8'h5A;
    localparam logic [7:0] K1     = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] timeoutV = 8'd0;
    logic       wr = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic       nrstReq, warnOut, activeOut, firedOut;

    typedef struct {
        logic nrst;
        logic warn;
        logic active;
        logic fired;
        int   edgeN;
    } expect_t;

    expect_t expQ[$];
    int      compared = 0;
    int      mismatched = 0;

    // Model: mode 0 stopped, 1 counting toward an absolute deadline edge, 2 pulsing.
    int nowEdge = 0;
    int mMode = 0;
    int mDeadline = 0;
    int mPulseEnd = 0;
    int mViolAt = -1;
    bit mArmed = 1'b0;
    bit mFired = 1'b0;

    wdt_rst_req #(
        .PRESC_DIV  (PRESC),
        .WARN_TICKS (WARN),
        .PULSE_LEN  (PULSE),
        .KEY0       (K0),
        .KEY1       (K1)
    ) dut (
        .clk        (clk),
        .rst_i      (rst),
        .en_i       (en),
        .timeout_i  (timeoutV),
        .wr_i       (wr),
        .wdata_i    (wdata),
        .nrst_req_o (nrstReq),
        .warn_o     (warnOut),
        .active_o   (activeOut),
        .fired_o    (firedOut)
    );

    always #5 clk = ~clk;

    function automatic int ticksOf(input logic [7:0] t);
        return (t == 8'd0) ? 1 : int'(t);
    endfunction

    task automatic modelFire();
        mMode     = 2;
        mPulseEnd = nowEdge + PULSE;
        mFired    = 1'b1;
        mArmed    = 1'b0;
        mViolAt   = -1;
    endtask

    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            nowEdge++;
            if (rst) begin
                mMode = 0; mArmed = 1'b0; mFired = 1'b0; mViolAt = -1;
            end else if (mMode == 0) begin
                if (wr) begin
                    if (wdata == K0) mArmed = 1'b1;
                    else if (mArmed) mArmed = 1'b0;
                end
                if (en) begin
                    mMode = 1;
                    mDeadline = nowEdge + ticksOf(timeoutV) * PRESC;
                end
            end else if (mMode == 1) begin
                if (mViolAt == nowEdge) begin
                    modelFire();
                end else if (wr && mArmed && wdata == K1) begin
                    mDeadline = nowEdge + ticksOf(timeoutV) * PRESC;
                    mArmed = 1'b0;
                end else begin
                    if (wr) begin
                        if (wdata == K0) begin
                            mArmed = 1'b1;
                        end else if (mArmed) begin
                            mArmed = 1'b0;
                            mViolAt = nowEdge + 1;
                        end
                    end
                    if (nowEdge == mDeadline) modelFire();
                end
            end else begin
                mArmed = 1'b0;
                if (nowEdge == mPulseEnd) mMode = 0;
            end
            e.nrst   = (mMode != 2);
            e.warn   = (mMode == 1) && (WARN > 0) && (nowEdge >= mDeadline - WARN * PRESC);
            e.active = (mMode == 1);
            e.fired  = mFired;
            e.edgeN  = nowEdge;
            expQ.push_back(e);
        end
    end

    task automatic checkOutput(input string name, input logic act, input logic req, input int edgeN);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s after edge %0d: got %b, expected %b", name, edgeN, act, req);
        end
    endtask

    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("nrst_req_o", nrstReq, e.nrst, e.edgeN);
                checkOutput("warn_o", warnOut, e.warn, e.edgeN);
                checkOutput("active_o", activeOut, e.active, e.edgeN);
                checkOutput("fired_o", firedOut, e.fired, e.edgeN);
            end
        end
    end

    task automatic applyStimulus(input logic rstV, input logic enV, input logic wrV,
                                 input logic [7:0] dataV, input logic [7:0] toV);
        @(negedge clk);
        rst = rstV; en = enV; wr = wrV; wdata = dataV; timeoutV = toV;
    endtask

    task automatic idleCycles(input int n, input logic enV);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, enV, 1'b0, 8'h00, 8'd3);
    endtask

    initial begin
        logic [7:0] d;
        int         pick;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd0);
        idleCycles(50, 1'b0);

        $display("[TB] plain expiry, timeout 3");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd3);
        idleCycles(25, 1'b0);

        $display("[TB] periodic service, enable dropped halfway");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd8);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, k < 10, 1'b1, K0, 8'd8);
            applyStimulus(1'b0, k < 10, 1'b1, K1, 8'd8);
            idleCycles(8, k < 10);
        end
        idleCycles(40, 1'b0);

        $display("[TB] key violation while running, then in idle");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd8);
        idleCycles(5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, K0, 8'd8);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 8'd8);
        idleCycles(10, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, K0, 8'd8);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 8'd8);
        idleCycles(3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, K1, 8'd8);
        idleCycles(10, 1'b0);

        $display("[TB] kick landing on the expiry edge");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd3);
        idleCycles(10, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, K0, 8'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, K1, 8'd3);
        idleCycles(20, 1'b0);

        $display("[TB] zero timeout and reset during the pulse");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd0);
        idleCycles(10, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd0);
        idleCycles(5, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd0);
        idleCycles(5, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            pick = int'($urandom_range(0, 9));
            d = (pick < 4) ? K0 : (pick < 8) ? K1 : (pick == 8) ? 8'h33 : 8'($urandom);
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0), d, 8'($urandom_range(0, 6)));
        end
        idleCycles(2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard drain: %0d left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
